// File: rtl/ctrl_pkg.sv
// Shared types and constants for the LED/buzzer command path.
package ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_BUZ  = 2'd3
    } op_e;

    typedef enum logic {
        SRC_BTN = 1'b0,
        SRC_IR  = 1'b1
    } src_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } out_state_e;

    typedef struct packed {
        logic pend;
        op_e  op;
    } slot_t;

    localparam logic [7:0] IR_INC_DEF = 8'h18;
    localparam logic [7:0] IR_DEC_DEF = 8'h52;
    localparam logic [7:0] IR_BUZ_DEF = 8'h1C;

    // Unmapped IR codes decode to OP_NONE, which callers treat as "no event".
    function automatic op_e ir_decode(input logic [7:0] code,
                                      input logic [7:0] c_inc,
                                      input logic [7:0] c_dec,
                                      input logic [7:0] c_buz);
        if (code == c_inc) return OP_INC;
        if (code == c_dec) return OP_DEC;
        if (code == c_buz) return OP_BUZ;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/ctrl_cmd_arbiter_btn_repeat.sv
// Button press detector: one event per falling edge, plus optional hold/auto-repeat events.
module btn_repeat #(
    parameter bit REPEAT_EN  = 1'b1,
    parameter int HOLD_CYC   = 25_000_000,
    parameter int REPEAT_CYC = 5_000_000,
    parameter int CNT_W      = 25
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_n_i,
    output logic evt_o
);

    logic             btn_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rep_q;
    logic             fall;
    logic             hit;

    assign fall = btn_q & ~btn_n_i;

    // cnt_q holds the number of cycles elapsed since the press or the last repeat event.
    assign hit = REPEAT_EN && !btn_q && !btn_n_i &&
                 (rep_q ? (cnt_q == CNT_W'(REPEAT_CYC)) : (cnt_q == CNT_W'(HOLD_CYC)));

    assign evt_o = fall | hit;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            btn_q <= 1'b1;
            cnt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            btn_q <= btn_n_i;
            if (btn_n_i || !REPEAT_EN) begin
                cnt_q <= '0;
                rep_q <= 1'b0;
            end else if (fall || hit) begin
                cnt_q <= CNT_W'(1);
                rep_q <= hit;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ctrl_cmd_arbiter.sv
// Merges button and IR commands into one valid/ready stream with one pending slot per source
// and round-robin grant between the two slots.
module ctrl_cmd_arbiter
    import ctrl_pkg::*;
#(
    parameter int         HOLD_CYC   = 25_000_000,
    parameter int         REPEAT_CYC = 5_000_000,
    parameter int         CNT_W      = 25,
    parameter logic [7:0] IR_INC     = IR_INC_DEF,
    parameter logic [7:0] IR_DEC     = IR_DEC_DEF,
    parameter logic [7:0] IR_BUZ     = IR_BUZ_DEF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       btn_inc_n_i,
    input  logic       btn_dec_n_i,
    input  logic       btn_buz_n_i,
    input  logic       irq_i,
    input  logic [7:0] command_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [1:0] op_o,
    output logic       src_o,
    output logic       overflow_o
);

    logic inc_evt, dec_evt, buz_evt;

    btn_repeat #(.REPEAT_EN(1'b1), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC), .CNT_W(CNT_W))
        u_inc (.clk_i(clk_i), .rst_n_i(rst_n_i), .btn_n_i(btn_inc_n_i), .evt_o(inc_evt));

    btn_repeat #(.REPEAT_EN(1'b1), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC), .CNT_W(CNT_W))
        u_dec (.clk_i(clk_i), .rst_n_i(rst_n_i), .btn_n_i(btn_dec_n_i), .evt_o(dec_evt));

    btn_repeat #(.REPEAT_EN(1'b0), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC), .CNT_W(CNT_W))
        u_buz (.clk_i(clk_i), .rst_n_i(rst_n_i), .btn_n_i(btn_buz_n_i), .evt_o(buz_evt));

    logic       btn_evt, ir_evt;
    op_e        btn_evt_op, ir_evt_op;
    slot_t      btn_slot_q, ir_slot_q;
    out_state_e state_q, state_d;
    op_e        op_q;
    src_e       src_q;
    logic       last_ir_q;
    logic       ovf_q;
    logic       grant, grant_ir, grant_btn;
    logic       btn_drop, ir_drop;

    // Simultaneous button events collapse to the highest-priority one; the rest vanish.
    always_comb begin
        btn_evt    = inc_evt | dec_evt | buz_evt;
        btn_evt_op = OP_NONE;
        if (inc_evt)      btn_evt_op = OP_INC;
        else if (dec_evt) btn_evt_op = OP_DEC;
        else if (buz_evt) btn_evt_op = OP_BUZ;
    end

    assign ir_evt_op = ir_decode(command_i, IR_INC, IR_DEC, IR_BUZ);
    assign ir_evt    = irq_i && (ir_evt_op != OP_NONE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        grant_ir = 1'b0;
        if ((state_q == ST_IDLE || ready_i) && (btn_slot_q.pend || ir_slot_q.pend)) begin
            grant    = 1'b1;
            grant_ir = ir_slot_q.pend && (!btn_slot_q.pend || !last_ir_q);
            state_d  = ST_OFFER;
        end else if (state_q == ST_OFFER && ready_i) begin
            state_d = ST_IDLE;
        end
    end

    assign grant_btn = grant && !grant_ir;

    // A slot being granted this cycle has room: the incoming event refills it.
    assign btn_drop = btn_evt && btn_slot_q.pend && !grant_btn;
    assign ir_drop  = ir_evt  && ir_slot_q.pend  && !grant_ir;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            btn_slot_q <= '{pend: 1'b0, op: OP_NONE};
            ir_slot_q  <= '{pend: 1'b0, op: OP_NONE};
            op_q       <= OP_NONE;
            src_q      <= SRC_BTN;
            last_ir_q  <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            ovf_q <= btn_drop | ir_drop;

            if (btn_evt && !btn_drop) btn_slot_q <= '{pend: 1'b1, op: btn_evt_op};
            else if (grant_btn)       btn_slot_q.pend <= 1'b0;

            if (ir_evt && !ir_drop) ir_slot_q <= '{pend: 1'b1, op: ir_evt_op};
            else if (grant_ir)      ir_slot_q.pend <= 1'b0;

            if (grant) begin
                op_q      <= grant_ir ? ir_slot_q.op : btn_slot_q.op;
                src_q     <= grant_ir ? SRC_IR : SRC_BTN;
                last_ir_q <= grant_ir;
            end else if (state_d == ST_IDLE) begin
                op_q  <= OP_NONE;
                src_q <= SRC_BTN;
            end
        end
    end

    assign valid_o    = (state_q == ST_OFFER);
    assign op_o       = op_q;
    assign src_o      = src_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_ctrl_cmd_arbiter.sv
// Bench for ctrl_cmd_arbiter: cycle model from the command rules, compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ctrl_cmd_arbiter;
    import ctrl_pkg::*;

    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic       clk_i       = 1'b0;
    logic       rst_n_i     = 1'b0;
    logic       btn_inc_n_i = 1'b1;
    logic       btn_dec_n_i = 1'b1;
    logic       btn_buz_n_i = 1'b1;
    logic       irq_i       = 1'b0;
    logic [7:0] command_i   = 8'h00;
    logic       ready_i     = 1'b0;
    logic       valid_o;
    logic [1:0] op_o;
    logic       src_o;
    logic       overflow_o;

    ctrl_cmd_arbiter #(.HOLD_CYC(HOLD), .REPEAT_CYC(REP), .CNT_W(5)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .btn_inc_n_i(btn_inc_n_i), .btn_dec_n_i(btn_dec_n_i), .btn_buz_n_i(btn_buz_n_i),
        .irq_i(irq_i), .command_i(command_i), .ready_i(ready_i),
        .valid_o(valid_o), .op_o(op_o), .src_o(src_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;
    int n_deliv [4] = '{default: 0};
    int n_ovf = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: cycles since press per button (-1 = released), slots, offer register.
    int         m_h [3];
    logic [1:0] m_pend;
    logic [1:0] m_sop [2];
    logic       m_valid;
    logic [1:0] m_op;
    logic       m_src;
    logic       m_last_ir;
    logic       m_ovf;

    always @(posedge clk_i or negedge rst_n_i) begin : model
        int         h [3];
        logic [2:0] low;
        logic [2:0] ev;
        logic [1:0] sev;
        logic [1:0] sop [2];
        logic [1:0] npend;
        logic [1:0] nsop [2];
        logic       drop;
        int         g;
        if (!rst_n_i) begin
            for (int i = 0; i < 3; i++) m_h[i] <= -1;
            m_pend    <= 2'b00;
            m_sop[0]  <= 2'd0;
            m_sop[1]  <= 2'd0;
            m_valid   <= 1'b0;
            m_op      <= 2'd0;
            m_src     <= 1'b0;
            m_last_ir <= 1'b1;
            m_ovf     <= 1'b0;
        end else begin
            low = {~btn_buz_n_i, ~btn_dec_n_i, ~btn_inc_n_i};
            for (int i = 0; i < 3; i++) begin
                h[i]  = !low[i] ? -1 : (m_h[i] < 0 ? 0 : m_h[i] + 1);
                ev[i] = low[i] && (h[i] == 0 ||
                        (i < 2 && h[i] >= HOLD && ((h[i] - HOLD) % REP) == 0));
                m_h[i] <= h[i];
            end
            sev[0] = |ev;
            sop[0] = ev[0] ? 2'd1 : (ev[1] ? 2'd2 : 2'd3);
            sev[1] = irq_i && (command_i == 8'h18 || command_i == 8'h52 || command_i == 8'h1C);
            sop[1] = (command_i == 8'h18) ? 2'd1 : ((command_i == 8'h52) ? 2'd2 : 2'd3);

            g = -1;
            if ((!m_valid || ready_i) && m_pend != 2'b00) begin
                if (m_pend == 2'b11) g = m_last_ir ? 0 : 1;
                else                 g = m_pend[0] ? 0 : 1;
            end

            drop = 1'b0;
            for (int s = 0; s < 2; s++) begin
                npend[s] = m_pend[s];
                nsop[s]  = m_sop[s];
                if (g == s) npend[s] = 1'b0;
                if (sev[s]) begin
                    if (npend[s]) drop = 1'b1;
                    else begin
                        npend[s] = 1'b1;
                        nsop[s]  = sop[s];
                    end
                end
            end
            m_pend   <= npend;
            m_sop[0] <= nsop[0];
            m_sop[1] <= nsop[1];
            m_ovf    <= drop;

            if (g >= 0) begin
                m_valid   <= 1'b1;
                m_op      <= m_sop[g];
                m_src     <= (g == 1);
                m_last_ir <= (g == 1);
            end else if (m_valid && ready_i) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (cmp_en) begin
            check("cmp_valid", {7'd0, valid_o}, {7'd0, m_valid});
            check("cmp_overflow", {7'd0, overflow_o}, {7'd0, m_ovf});
            if (m_valid) begin
                check("cmp_op", {6'd0, op_o}, {6'd0, m_op});
                check("cmp_src", {7'd0, src_o}, {7'd0, m_src});
            end
        end
        if (rst_n_i && valid_o && ready_i) n_deliv[op_o]++;
        if (rst_n_i && overflow_o) n_ovf++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic pin_offer(input string name, input logic [1:0] op, input logic src);
        check({name, "_valid"}, {7'd0, valid_o}, 8'd1);
        check({name, "_op"}, {6'd0, op_o}, {6'd0, op});
        check({name, "_src"}, {7'd0, src_o}, {7'd0, src});
    endtask

    function automatic int total_deliv();
        return n_deliv[0] + n_deliv[1] + n_deliv[2] + n_deliv[3];
    endfunction

    initial begin
        tick(2);
        cmp_en = 1'b1;
        @(negedge clk_i);
        check("rst_valid", {7'd0, valid_o}, 8'd0);
        check("rst_op", {6'd0, op_o}, 8'd0);
        check("rst_src", {7'd0, src_o}, 8'd0);
        check("rst_ovf", {7'd0, overflow_o}, 8'd0);
        tick(1);
        rst_n_i = 1'b1;
        tick(3);

        // Tie between IR buzz and button inc: first tie goes to the button.
        ready_i = 1'b1;
        btn_inc_n_i = 1'b0; irq_i = 1'b1; command_i = 8'h1C;
        tick(1);
        irq_i = 1'b0; command_i = 8'h00;
        tick(1);
        @(negedge clk_i); pin_offer("tie_first", 2'd1, 1'b0);
        tick(1);
        @(negedge clk_i); pin_offer("tie_second", 2'd3, 1'b1);
        tick(1);
        @(negedge clk_i); check("tie_idle", {7'd0, valid_o}, 8'd0);
        btn_inc_n_i = 1'b1;
        tick(4);

        // Single inc press, held below the repeat threshold: one offer at t+2.
        btn_inc_n_i = 1'b0;
        tick(2);
        @(negedge clk_i); pin_offer("inc_press", 2'd1, 1'b0);
        tick(1);
        @(negedge clk_i); check("inc_one_cycle", {7'd0, valid_o}, 8'd0);
        tick(14);
        btn_inc_n_i = 1'b1;
        tick(4);
        check("inc_count", 8'(n_deliv[1]), 8'd2);

        // Dec held 40 cycles: press plus repeats at hold counts 20, 28, 36.
        btn_dec_n_i = 1'b0;
        tick(40);
        btn_dec_n_i = 1'b1;
        tick(12);
        check("dec_repeat_count", 8'(n_deliv[2]), 8'd4);

        // Consumer stalled: three buz presses; the third finds the slot full.
        ready_i = 1'b0;
        btn_buz_n_i = 1'b0; tick(2); btn_buz_n_i = 1'b1; tick(2);
        btn_buz_n_i = 1'b0; tick(2); btn_buz_n_i = 1'b1; tick(2);
        btn_buz_n_i = 1'b0; tick(2); btn_buz_n_i = 1'b1;
        tick(3);
        @(negedge clk_i); pin_offer("buz_stall", 2'd3, 1'b0);
        check("buz_ovf_count", 8'(n_ovf), 8'd1);
        ready_i = 1'b1;
        tick(5);
        check("buz_count", 8'(n_deliv[3]), 8'd3);

        // Unmapped IR codes are ignored.
        irq_i = 1'b1; command_i = 8'h00; tick(1);
        command_i = 8'h55; tick(1);
        irq_i = 1'b0; command_i = 8'h00;
        tick(4);
        @(negedge clk_i); check("ir_unmapped_idle", {7'd0, valid_o}, 8'd0);
        check("ir_unmapped_ovf", 8'(n_ovf), 8'd1);
        check("ir_unmapped_total", 8'(total_deliv()), 8'd9);

        // IR refill during grant, IR overflow, then round-robin over both slots.
        ready_i = 1'b0;
        irq_i = 1'b1; command_i = 8'h18; tick(1);
        command_i = 8'h52; tick(1);
        command_i = 8'h18; tick(1);
        irq_i = 1'b0; command_i = 8'h00; btn_dec_n_i = 1'b0; tick(2);
        btn_dec_n_i = 1'b1; tick(2);
        check("ir_ovf_count", 8'(n_ovf), 8'd2);
        ready_i = 1'b1;
        @(negedge clk_i); pin_offer("rr_0", 2'd1, 1'b1);
        tick(1);
        @(negedge clk_i); pin_offer("rr_1", 2'd2, 1'b0);
        tick(1);
        @(negedge clk_i); pin_offer("rr_2", 2'd2, 1'b1);
        tick(1);
        @(negedge clk_i); check("rr_idle", {7'd0, valid_o}, 8'd0);
        check("rr_total", 8'(total_deliv()), 8'd12);

        // Reset mid-offer with another command pending: nothing survives.
        ready_i = 1'b0;
        btn_inc_n_i = 1'b0; tick(1);
        btn_inc_n_i = 1'b1; tick(1);
        btn_dec_n_i = 1'b0; tick(2);
        @(negedge clk_i); pin_offer("pre_reset", 2'd1, 1'b0);
        #2 rst_n_i = 1'b0;
        #1;
        check("async_rst_valid", {7'd0, valid_o}, 8'd0);
        check("async_rst_op", {6'd0, op_o}, 8'd0);
        check("async_rst_src", {7'd0, src_o}, 8'd0);
        check("async_rst_ovf", {7'd0, overflow_o}, 8'd0);
        btn_dec_n_i = 1'b1;
        tick(2);
        rst_n_i = 1'b1;
        ready_i = 1'b1;
        tick(10);
        @(negedge clk_i); check("post_reset_idle", {7'd0, valid_o}, 8'd0);
        check("post_reset_total", 8'(total_deliv()), 8'd12);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
